// File: rtl/playlist_mcu.sv
// ----------------------------------------------------------------------------
// playlist_mcu
//
// Playback controller between the launchpad decoder and the song player.
// It latches a requested song index, then drives the player through
// LOAD (reset_player pulse), PLAY and PAUSE. At end of song it stops,
// repeats or advances (with wrap-around), depending on mode.
//
// While en is low (the controller is frozen by the colour-change logic),
// launchpad and player strobes are held in pending flags. They are
// consumed on the next enabled cycle.
//
// Parameters
//   SONG_W      width of the song index
//   NUM_SONGS   number of valid songs (indices 0..NUM_SONGS-1)
//   RST_CYCLES  length of the reset_player pulse, in enabled cycles
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset, overrides en
//   en            advance enable; state, song and counter move only when high
//   song_sel      requested song index
//   sel_valid     one-cycle strobe qualifying song_sel
//   pause_toggle  one-cycle strobe toggling PLAY/PAUSE
//   mode          end-of-song policy: 00 single, 01 repeat, 10 advance,
//                 11 single
//   song_done     end-of-song strobe from the player
//   play          high in PLAY only
//   reset_player  high in LOAD only
//   song          current song index
//   state         WAIT=0, LOAD=1, PLAY=2, PAUSE=3
// ----------------------------------------------------------------------------
module playlist_mcu #(
  parameter int SONG_W     = 4,
  parameter int NUM_SONGS  = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              sel_valid,
  input  logic              pause_toggle,
  input  logic [1:0]        mode,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t              cur;
  logic [CNT_W-1:0]    cnt;
  logic                sel_pend;
  logic [SONG_W-1:0]   sel_idx;
  logic                pause_pend;
  logic                done_pend;
  logic                play_q;
  logic                reset_player_q;
  logic [SONG_W-1:0]   song_q;

  logic                sel_in_range;
  logic                sel_ok;
  logic                eff_sel;
  logic [SONG_W-1:0]   eff_idx;
  logic                eff_pause;
  logic                eff_done;
  logic                load_last;
  logic [SONG_W-1:0]   next_song;

  // Effective requests: a pending flag or a strobe arriving this cycle.
  // The comparison is widened by one bit so NUM_SONGS = 2^SONG_W fits.
  always_comb begin
    sel_in_range = ({1'b0, song_sel} < (SONG_W+1)'(NUM_SONGS));
    sel_ok       = sel_valid && sel_in_range;
    eff_sel      = sel_pend || sel_ok;
    if (sel_ok) begin
      eff_idx = song_sel;
    end else begin
      eff_idx = sel_idx;
    end
    eff_pause = pause_pend || pause_toggle;
    eff_done  = done_pend || song_done;
    load_last = (cnt == CNT_W'(RST_CYCLES - 1));
    if (song_q == SONG_W'(NUM_SONGS - 1)) begin
      next_song = SONG_W'(0);
    end else begin
      next_song = song_q + SONG_W'(1);
    end
  end

  // Controller FSM with pending buffers and registered Moore outputs.
  // Every entry into LOAD restarts the pulse counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur            <= ST_WAIT;
      cnt            <= CNT_W'(0);
      sel_pend       <= 1'b0;
      sel_idx        <= SONG_W'(0);
      pause_pend     <= 1'b0;
      done_pend      <= 1'b0;
      song_q         <= SONG_W'(0);
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
    end else if (en) begin
      // Everything effective is consumed now; nothing is re-buffered.
      sel_pend   <= 1'b0;
      pause_pend <= 1'b0;
      done_pend  <= 1'b0;
      case (cur)
        ST_WAIT: begin
          if (eff_sel) begin
            song_q         <= eff_idx;
            cnt            <= CNT_W'(0);
            cur            <= ST_LOAD;
            reset_player_q <= 1'b1;
            play_q         <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (eff_sel) begin
            song_q <= eff_idx;
            cnt    <= CNT_W'(0);
          end else if (load_last) begin
            cnt            <= CNT_W'(0);
            cur            <= ST_PLAY;
            reset_player_q <= 1'b0;
            play_q         <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (eff_sel) begin
            song_q         <= eff_idx;
            cnt            <= CNT_W'(0);
            cur            <= ST_LOAD;
            reset_player_q <= 1'b1;
            play_q         <= 1'b0;
          end else if (eff_done) begin
            case (mode)
              2'b01: begin
                cnt            <= CNT_W'(0);
                cur            <= ST_LOAD;
                reset_player_q <= 1'b1;
                play_q         <= 1'b0;
              end
              2'b10: begin
                song_q         <= next_song;
                cnt            <= CNT_W'(0);
                cur            <= ST_LOAD;
                reset_player_q <= 1'b1;
                play_q         <= 1'b0;
              end
              default: begin
                cur            <= ST_WAIT;
                reset_player_q <= 1'b0;
                play_q         <= 1'b0;
              end
            endcase
          end else if (eff_pause) begin
            cur    <= ST_PAUSE;
            play_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (eff_sel) begin
            song_q         <= eff_idx;
            cnt            <= CNT_W'(0);
            cur            <= ST_LOAD;
            reset_player_q <= 1'b1;
            play_q         <= 1'b0;
          end else if (eff_pause) begin
            cur    <= ST_PLAY;
            play_q <= 1'b1;
          end
        end
        default: begin
          cur            <= ST_WAIT;
          cnt            <= CNT_W'(0);
          reset_player_q <= 1'b0;
          play_q         <= 1'b0;
        end
      endcase
    end else begin
      // Frozen: buffer strobes; the last in-range selection wins.
      if (sel_ok) begin
        sel_pend <= 1'b1;
        sel_idx  <= song_sel;
      end
      if (pause_toggle) begin
        pause_pend <= 1'b1;
      end
      if (song_done) begin
        done_pend <= 1'b1;
      end
    end
  end

  assign play         = play_q;
  assign reset_player = reset_player_q;
  assign song         = song_q;
  assign state        = cur;

endmodule
